trap_controller: RTL
====================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 The block SHALL have parameter: VECTORED_SUPPORT, 1, enables vectored mtvec mode; when 0, MODE 01 is treated as direct.
REQ-002 The block SHALL have port: clk_i  in  1  single clock, all logic on rising edge.
REQ-003 The block SHALL have port: rst_n_i  in  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port: exception_i  in  1  committing instruction raised an exception (level, valid with the fields below).
REQ-005 The block SHALL have port: exception_code_i  in  5  exception code (INSTR_ADDR_MISALIGNED..DIVIDE_BY_ZERO).
REQ-006 The block SHALL have port: exception_pc_i  in  32  PC of the faulting instruction.
REQ-007 The block SHALL have port: next_pc_i  in  32  PC of the next instruction to commit (interrupt return address).
REQ-008 The block SHALL have port: int_window_i  in  1  instruction boundary; interrupts may be taken this cycle.
REQ-009 The block SHALL have port: mret_i  in  1  committing MRET.
REQ-010 The block SHALL have ports: ext_irq_i, timer_irq_i, sw_irq_i  in  1 each  machine pending sources (MEIP, MTIP, MSIP).
REQ-011 The block SHALL have port: mie_i  in  12  interrupt-enable CSR (bits MEIE=11, MTIE=7, MSIE=3).
REQ-012 The block SHALL have port: mtvec_i  in  32  {BASE[31:2], MODE[1:0]}.
REQ-013 The block SHALL have ports: csr_mepc_we_i  in  1; csr_mstatus_we_i  in  1; csr_wdata_i  in  32  software CSR writes.
REQ-014 The block SHALL have ports: mepc_o  out  32; mcause_o  out  32; mstatus_mie_o, mstatus_mpie_o  out  1; mstatus_mpp_o  out  2; privilege_o  out  2.
REQ-015 The block SHALL have ports: redirect_o  out  1; redirect_pc_o  out  32; fetch_ready_i  in  1  redirect handshake.
REQ-016 The block SHALL have ports: flush_o  out  1  pipeline flush pulse; stall_o  out  1  commit stage must hold.

Function
REQ-017 The FSM SHALL have states IDLE, SAVE, JUMP, RETURN.
REQ-018 In IDLE, exception_i SHALL have priority over mret_i, which SHALL have priority over interrupts.
REQ-019 An interrupt SHALL be taken only when int_window_i=1, mstatus_mie_o=1, and the source is pending and enabled.
REQ-020 Interrupt priority SHALL be MEI(11) > MSI(3) > MTI(7).
REQ-021 On a trap, IDLE->SAVE SHALL latch the cause and return PC (exception_pc_i for exceptions, next_pc_i for interrupts).
REQ-022 The exception cause SHALL be {1'b0, 26'b0, exception_code_i}; the interrupt cause SHALL be {1'b1, 31'd code}.
REQ-023 SAVE (1 cycle) SHALL write mepc_o = return PC with bits[1:0] forced to 0, and write mcause_o.
REQ-024 SAVE SHALL set MPIE<=MIE, MIE<=0, MPP<=privilege_o, privilege_o<=MACHINE (2'b11); then go to JUMP.
REQ-025 In SAVE, redirect_pc_o SHALL be {BASE,2'b00}, or {BASE,2'b00}+4*code for an interrupt when MODE=01 and VECTORED_SUPPORT=1; MODE 10/11 SHALL be treated as direct; arithmetic is 32-bit, wrapping.
REQ-026 On mret_i in IDLE, the FSM SHALL go to RETURN; RETURN (1 cycle) SHALL set MIE<=MPIE, MPIE<=1, privilege_o<=MPP, MPP<=USER, redirect_pc_o<=mepc_o, then go to JUMP.
REQ-027 In JUMP, redirect_o SHALL be 1 with redirect_pc_o stable until the cycle fetch_ready_i=1, then return to IDLE; redirect_o SHALL deassert the following cycle.
REQ-028 flush_o SHALL pulse for exactly one cycle on entry to SAVE or RETURN.
REQ-029 stall_o SHALL be 1 in SAVE, RETURN and JUMP; all trap/mret/interrupt inputs SHALL be ignored outside IDLE.
REQ-030 Software CSR writes SHALL apply only in IDLE: mepc <= wdata with [1:0]=0; mstatus_we updates MIE(bit3), MPIE(bit7), MPP(bits12:11).
REQ-031 An MPP write of 2'b01 or 2'b10 SHALL store USER (WARL).
REQ-032 A trap or mret in the same IDLE cycle as a CSR write SHALL take precedence; the CSR write is dropped.
REQ-033 Latency from trap detect to first redirect_o SHALL be 2 cycles (IDLE->SAVE->JUMP).

Reset
REQ-034 While rst_n_i=0 at a clock edge, the block SHALL set state=IDLE, mepc_o=0, mcause_o=0, MIE=0, MPIE=0, MPP=USER, privilege_o=MACHINE, redirect_o=0, redirect_pc_o=0, flush_o=0, stall_o=0.
REQ-035 Reset asserted in any state, including JUMP awaiting fetch_ready_i, SHALL abort the pending redirect.

Verification
REQ-036 The bench SHALL cover: exception_i with code 2 at PC 0x100, mtvec=0x8000_0001 -> mcause=0x2, mepc=0x100, redirect_pc=0x8000_0000, MIE=0.
REQ-037 The bench SHALL cover: MIE=1, mie=0x888, ext and timer pending, int_window=1, next_pc=0x204, vectored mtvec=0x8000_0001 -> mcause=0x8000_000B, mepc=0x204, redirect_pc=0x8000_002C.
REQ-038 The bench SHALL cover: trap then mret -> MIE restored to 1, MPIE=1, privilege=MPP, MPP=USER, redirect_pc=mepc.
REQ-039 The bench SHALL cover: fetch_ready_i held 0 for 5 cycles in JUMP -> redirect_o and redirect_pc_o stable; new exception_i ignored.
REQ-040 The bench SHALL cover: exception_i and mret_i in the same cycle together with a CSR mepc write -> exception taken, CSR write dropped.
REQ-041 The bench SHALL cover: rst_n_i=0 during JUMP -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/trap_controller.sv
// ============================================================================
// trap_controller : machine-mode trap/interrupt/MRET sequencer with redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module trap_controller #(
  parameter int unsigned VECTORED_SUPPORT = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        exception_i,
  input  logic [4:0]  exception_code_i,
  input  logic [31:0] exception_pc_i,
  input  logic [31:0] next_pc_i,
  input  logic        int_window_i,
  input  logic        mret_i,
  input  logic        ext_irq_i,
  input  logic        timer_irq_i,
  input  logic        sw_irq_i,
  input  logic [11:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic        csr_mepc_we_i,
  input  logic        csr_mstatus_we_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] mepc_o,
  output logic [31:0] mcause_o,
  output logic        mstatus_mie_o,
  output logic        mstatus_mpie_o,
  output logic [1:0]  mstatus_mpp_o,
  output logic [1:0]  privilege_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  input  logic        fetch_ready_i,
  output logic        flush_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAVE   = 2'd1,
    JUMP   = 2'd2,
    RETURN = 2'd3
  } state_t;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [1:0]  mpp_q, mpp_d;
  logic [1:0]  priv_q, priv_d;
  logic        redirect_q, redirect_d;
  logic        flush_q, flush_d;

  logic        irq_ext, irq_sw, irq_tmr, irq_take;
  logic [4:0]  irq_code;
  logic [31:0] tvec_base, tvec_target;
  logic        use_vector;
  logic        unused_inputs;

  assign irq_ext  = ext_irq_i   & mie_i[11];
  assign irq_sw   = sw_irq_i    & mie_i[3];
  assign irq_tmr  = timer_irq_i & mie_i[7];
  assign irq_take = int_window_i & mie_q & (irq_ext | irq_sw | irq_tmr);

  always_comb begin
    irq_code = 5'd0;
    if (irq_ext)      irq_code = 5'd11;
    else if (irq_sw)  irq_code = 5'd3;
    else if (irq_tmr) irq_code = 5'd7;
  end

  // Only MODE=01 vectors, and only for interrupts; 10/11 fall back to direct.
  assign tvec_base   = {mtvec_i[31:2], 2'b00};
  assign use_vector  = (VECTORED_SUPPORT != 0) && (mtvec_i[1:0] == 2'b01) && cause_q[31];
  assign tvec_target = use_vector ? (tvec_base + {cause_q[29:0], 2'b00}) : tvec_base;

  assign unused_inputs = ^{mie_i[10:8], mie_i[6:4], mie_i[2:0], csr_wdata_i[1:0]};

  always_comb begin
    state_d       = state_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    cause_d       = cause_q;
    ret_pc_d      = ret_pc_q;
    redirect_pc_d = redirect_pc_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mpp_d         = mpp_q;
    priv_d        = priv_q;
    redirect_d    = redirect_q;
    flush_d       = 1'b0;

    case (state_q)
      IDLE: begin
        redirect_d = 1'b0;
        if (exception_i) begin
          state_d  = SAVE;
          flush_d  = 1'b1;
          cause_d  = {1'b0, 26'd0, exception_code_i};
          ret_pc_d = exception_pc_i;
        end else if (mret_i) begin
          state_d = RETURN;
          flush_d = 1'b1;
        end else if (irq_take) begin
          state_d  = SAVE;
          flush_d  = 1'b1;
          cause_d  = {1'b1, 26'd0, irq_code};
          ret_pc_d = next_pc_i;
        end else begin
          if (csr_mepc_we_i) mepc_d = {csr_wdata_i[31:2], 2'b00};
          if (csr_mstatus_we_i) begin
            mie_d  = csr_wdata_i[3];
            mpie_d = csr_wdata_i[7];
            // WARL: only U and M are legal previous privileges.
            mpp_d  = (csr_wdata_i[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
          end
        end
      end
      SAVE: begin
        mepc_d        = {ret_pc_q[31:2], 2'b00};
        mcause_d      = cause_q;
        mpie_d        = mie_q;
        mie_d         = 1'b0;
        mpp_d         = priv_q;
        priv_d        = PRIV_M;
        redirect_pc_d = tvec_target;
        redirect_d    = 1'b1;
        state_d       = JUMP;
      end
      RETURN: begin
        mie_d         = mpie_q;
        mpie_d        = 1'b1;
        priv_d        = mpp_q;
        mpp_d         = PRIV_U;
        redirect_pc_d = mepc_q;
        redirect_d    = 1'b1;
        state_d       = JUMP;
      end
      JUMP: begin
        if (fetch_ready_i) begin
          redirect_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      cause_q       <= 32'd0;
      ret_pc_q      <= 32'd0;
      redirect_pc_q <= 32'd0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mpp_q         <= PRIV_U;
      priv_q        <= PRIV_M;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      cause_q       <= cause_d;
      ret_pc_q      <= ret_pc_d;
      redirect_pc_q <= redirect_pc_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mpp_q         <= mpp_d;
      priv_q        <= priv_d;
      redirect_q    <= redirect_d;
      flush_q       <= flush_d;
    end
  end

  assign mepc_o         = mepc_q;
  assign mcause_o       = mcause_q;
  assign mstatus_mie_o  = mie_q;
  assign mstatus_mpie_o = mpie_q;
  assign mstatus_mpp_o  = mpp_q;
  assign privilege_o    = priv_q;
  assign redirect_o     = redirect_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign flush_o        = flush_q;
  assign stall_o        = (state_q != IDLE);

endmodule

`default_nettype wire
